// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer.
// Latches two WIDTH-bit operands and an opcode. It then processes one bit pair
// per clock, LSB first, through a 1-bit slice with a 4:1 result select. The
// result bits are shifted back into a WIDTH-bit word, and the block raises
// done, carry_out and zero at the end of the operation.
module alu_serial_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero
);

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               accept;
    logic               last;

    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [1:0]         op_reg;
    logic               carry;
    logic [CNT_W-1:0]   cnt;

    logic               b_eff;
    logic               sum_bit;
    logic               c_next;
    logic               r_bit;
    logic [WIDTH-1:0]   result_next;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking (<=) so every flop
            // samples pre-edge values regardless of statement order.
            state <= state_next;
        end
    end

    // Next-state logic: accept start in IDLE/DONE, and finish after the last bit.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned (which would infer a latch).
        state_next = state;
        accept     = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    last       = 1'b1;
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // 1-bit slice: B is inverted for SUB, and the 4:1 select is driven by the latched opcode.
    always_comb begin
        b_eff   = b_reg[0] ^ (op_reg == OP_SUB);
        sum_bit = a_reg[0] ^ b_eff ^ carry;
        c_next  = (a_reg[0] & b_eff) | (a_reg[0] & carry) | (b_eff & carry);
        r_bit   = 1'b0;
        case (op_reg)
            OP_AND:         r_bit = a_reg[0] & b_reg[0];
            OP_OR:          r_bit = a_reg[0] | b_reg[0];
            OP_ADD, OP_SUB: r_bit = sum_bit;
            default:        r_bit = 1'b0;
        endcase
        result_next = {r_bit, result[WIDTH-1:1]};
    end

    // Datapath: operand latch/shift, carry flop, bit counter, result collection and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the operand and result registers are plain flops, not a
            // memory array, so they can all be reset to a known value.
            a_reg     <= '0;
            b_reg     <= '0;
            op_reg    <= OP_AND;
            carry     <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                a_reg     <= a;
                b_reg     <= b;
                op_reg    <= op;
                carry     <= (op == OP_SUB);
                cnt       <= '0;
                busy      <= 1'b1;
                result    <= '0;
                carry_out <= 1'b0;
                zero      <= 1'b0;
            end else if (state == RUN) begin
                a_reg  <= a_reg >> 1;
                b_reg  <= b_reg >> 1;
                result <= result_next;
                if (op_reg[1]) begin
                    carry <= c_next;
                end
                if (last) begin
                    cnt       <= '0;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    zero      <= (result_next == '0);
                    carry_out <= op_reg[1] ? c_next : 1'b0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Testbench for alu_serial_seq. Stimulus pushes the hand-computed expected results
// into a scoreboard queue. A monitor pops one entry on each done pulse and compares it.
module tb_alu_serial_seq;

    localparam int WIDTH = 32;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             zero;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             c;
        logic             z;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;
    int   done_count  = 0;
    int   busy_run    = 0;

    alu_serial_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .op        (op),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [WIDTH-1:0] actual,
                         input logic [WIDTH-1:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: counts busy cycles and, on each done pulse, checks the DUT against the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_run = 0;
            end else begin
                if (busy) busy_run++;
                if (done) begin
                    done_count++;
                    check("busy_cycles", busy_run, WIDTH);
                    busy_run = 0;
                    if (sb.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        mon_e = sb.pop_front();
                        check("result", result, mon_e.res);
                        check("carry_out", {31'b0, carry_out}, {31'b0, mon_e.c});
                        check("zero", {31'b0, zero}, {31'b0, mon_e.z});
                    end
                end
            end
        end
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    // Drive one start pulse from a negedge. Optionally push its expected response.
    task automatic issue(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                         input logic [1:0] top, input bit push,
                         input logic [WIDTH-1:0] eres, input logic ec, input logic ez);
        exp_t e;
        e.res = eres;
        e.c   = ec;
        e.z   = ez;
        start = 1'b1;
        a     = ta;
        b     = tb_v;
        op    = top;
        if (push) sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait, with a bounded number of cycles, until the monitor has consumed every expectation.
    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, sb.size(), 0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_busy"}, {31'b0, busy}, 0);
        check({name, "_done"}, {31'b0, done}, 0);
        check({name, "_result"}, result, 0);
        check({name, "_carry_out"}, {31'b0, carry_out}, 0);
        check({name, "_zero"}, {31'b0, zero}, 0);
    endtask

    initial begin
        int dc;
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        op    = OP_AND;

        // Reset state.
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD with wrap-around into carry_out.
        issue(32'hFFFF_FFFF, 32'h0000_0001, OP_ADD, 1, 32'h0000_0000, 1'b1, 1'b1);
        wait_drain("add_wrap_timeout");

        // SUB with borrow.
        issue(32'h0000_0005, 32'h0000_0007, OP_SUB, 1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        wait_drain("sub_borrow_timeout");

        // AND, then check that the outputs hold after DONE.
        issue(32'hF0F0_F0F0, 32'hFF00_FF00, OP_AND, 1, 32'hF000_F000, 1'b0, 1'b0);
        wait_drain("and_timeout");
        repeat (3) @(negedge clk);
        check("hold_result", result, 32'hF000_F000);
        check("hold_done", {31'b0, done}, 0);
        check("hold_busy", {31'b0, busy}, 0);

        // OR.
        issue(32'hF0F0_F0F0, 32'hFF00_FF00, OP_OR, 1, 32'hFFF0_FFF0, 1'b0, 1'b0);
        wait_drain("or_timeout");

        // A start pulse during RUN with different operands is ignored.
        dc = done_count;
        issue(32'd10, 32'd20, OP_ADD, 1, 32'd30, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        issue(32'd1000, 32'd1, OP_OR, 0, '0, 1'b0, 1'b0);
        a = 32'hDEAD_BEEF;
        b = 32'h1234_5678;
        wait_drain("ignore_start_timeout");
        repeat (40) @(negedge clk);
        check("single_done", done_count - dc, 1);

        // Back-to-back: a start held high in the DONE cycle is accepted immediately.
        issue(32'd9, 32'd2, OP_SUB, 1, 32'd7, 1'b1, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 100);
        check("b2b_first_done", {31'b0, done}, 1);
        issue(32'd3, 32'd4, OP_ADD, 1, 32'h0000_0007, 1'b0, 1'b0);
        check("b2b_busy", {31'b0, busy}, 1);
        check("b2b_result_cleared", result, 0);
        check("b2b_carry_cleared", {31'b0, carry_out}, 0);
        wait_drain("b2b_timeout");

        // A reset during RUN aborts the operation, and no done pulse follows.
        issue(32'h1234_5678, 32'h0000_0001, OP_ADD, 0, '0, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        dc = done_count;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        check("abort_no_done", done_count - dc, 0);
        check_all_zero("abort_idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_serial_seq.md
Name: alu_serial_seq

Overview:
- Bit-serial sequencer for the 1-bit ALU slice datapath.
- On the input side it latches two WIDTH-bit operands and an opcode. It then feeds one bit pair per clock, LSB first, through an internal 1-bit slice whose 4:1 result select is driven by the opcode. A carry flop links the bits.
- On the output side it collects the result bits back into a WIDTH-bit word with done/carry/zero flags.
- It sits between the word-level control logic and the 1-bit slice. It is the word-level driver and collector for the slice's 4:1 select.

Parameters:
- WIDTH, 32, operand/result width in bits (≥2).
- CNT_W, $clog2(WIDTH), width of the internal bit counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only when not busy.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  2  opcode: 00 AND, 01 OR, 10 ADD, 11 SUB (A−B).
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when the result is valid.
- result  output  WIDTH  assembled result.
- carry_out  output  1  final carry (ADD), or no-borrow flag (SUB); 0 for AND/OR.
- zero  output  1  result == 0.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, busy=0, done=0, result=0, carry_out=0, zero=0, counter=0, carry flop=0, operand registers=0.
- A reset mid-operation aborts immediately; no done pulse follows.
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1 at edge E0:
  - latch a, b, op;
  - carry flop = 1 if op=SUB, else 0;
  - counter=0; go to RUN; busy=1.
  - A start arriving in DONE is accepted, so back-to-back operations are legal.
- IDLE/DONE with start=0: DONE goes to IDLE; IDLE stays in IDLE.
- RUN, each edge processes bit i = counter:
  - The b bit is b_i for ADD and ~b_i for SUB.
  - AND: r = a_i & b_i.
  - OR: r = a_i | b_i.
  - ADD/SUB: r = a_i ^ b' ^ c, new c = majority(a_i, b', c).
  - AND/OR leave the carry flop unchanged.
  - The result shift register shifts right with r entering at the MSB; the operand registers shift right.
  - counter increments.
- RUN, bit WIDTH−1 (the edge at E_WIDTH): go to DONE.
  - done=1 for exactly one cycle; busy=0.
  - result holds the full word; zero is computed from the final word.
  - carry_out = final carry for ADD/SUB, 0 for AND/OR.
- Latency: the start edge is E0; done is visible after edge E_WIDTH (32 cycles at the default). busy is high for exactly WIDTH cycles.
- start while busy (RUN) is ignored, and operand/op input changes during RUN have no effect.
- result, carry_out and zero hold their values from DONE until the next accepted start. On an accepted start they are cleared (result=0, flags=0).
- Wrap-around: ADD overflow discards the bit beyond WIDTH into carry_out. SUB with A<B yields a two's-complement result with carry_out=0.
- The counter never exceeds WIDTH−1. All outputs are registered.

Test Plan:
- Reset → all outputs 0; assert rst_n low mid-RUN → outputs 0, state IDLE, no done pulse.
- ADD a=0xFFFFFFFF b=0x00000001 → after 32 edges done=1, result=0x00000000, carry_out=1, zero=1; busy high exactly 32 cycles.
- SUB a=0x00000005 b=0x00000007 → result=0xFFFFFFFE, carry_out=0, zero=0.
- AND a=0xF0F0F0F0 b=0xFF00FF00 → result=0xF000F000. OR on the same operands → result=0xFFF0FFF0. carry_out=0 for both.
- start pulsed mid-RUN with different operands → ignored; first result is unchanged and only one done pulse occurs.
- start held high in the DONE cycle with ADD a=3 b=4 → new operation accepted immediately; result=0x00000007 after a further 32 edges.
